// File: rtl/muldiv_seq_if.sv
// Handshake bundle between the execute stage and the multi-cycle multiply/divide unit.
interface muldiv_seq_if #(
    parameter int unsigned XLEN = 32
);
    logic            START;
    logic            READY;
    logic [4:0]      SELECT;
    logic [XLEN-1:0] DATA1;
    logic [XLEN-1:0] DATA2;
    logic            FLUSH;
    logic [XLEN-1:0] RESULT;
    logic            VALID;
    logic            ACK;
    logic            BUSY;

    modport slave (
        input  START, SELECT, DATA1, DATA2, FLUSH, ACK,
        output READY, RESULT, VALID, BUSY
    );

    modport master (
        output START, SELECT, DATA1, DATA2, FLUSH, ACK,
        input  READY, RESULT, VALID, BUSY
    );
endinterface

// File: rtl/muldiv_seq.sv
// Shared 32-iteration shift-add / restoring-divide engine for the RV32M operations.
// The final value is staged in r_lo and copied to RESULT on the cycle after entering DONE.
module muldiv_seq #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 5
) (
    input  logic         CLK,
    input  logic         RESETN,
    muldiv_seq_if.slave  bus
);
    typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  MinInt = {1'b1, {(XLEN-1){1'b0}}};

    state_e           r_state, w_state_nx;
    logic [CNT_W-1:0] r_cnt, w_cnt_nx;
    logic [2:0]       r_op, w_op_nx;
    logic             r_nega, w_nega_nx;
    logic             r_negb, w_negb_nx;
    logic [XLEN-1:0]  r_opnd, w_opnd_nx;
    logic [XLEN-1:0]  r_hi, w_hi_nx;
    logic [XLEN-1:0]  r_lo, w_lo_nx;
    logic [XLEN-1:0]  r_result, w_result_nx;
    logic             r_valid, w_valid_nx;

    logic [2:0]        w_func;
    logic              w_is_m;
    logic              w_sgn_a, w_sgn_b;
    logic              w_nega, w_negb;
    logic [XLEN-1:0]   w_mag_a, w_mag_b;
    logic [XLEN:0]     w_sum;
    logic [XLEN:0]     w_shift;
    logic [XLEN:0]     w_diff;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_q, w_r;

    // Request decode; only func7 = 0000001 belongs to the M extension.
    assign w_func  = bus.SELECT[4:2];
    assign w_is_m  = (bus.SELECT[1:0] == 2'b01);
    assign w_sgn_a = w_is_m && (w_func == 3'd1 || w_func == 3'd2 || w_func == 3'd4 ||
                                w_func == 3'd6);
    assign w_sgn_b = w_is_m && (w_func == 3'd1 || w_func == 3'd4 || w_func == 3'd6);
    assign w_nega  = w_sgn_a && bus.DATA1[XLEN-1];
    assign w_negb  = w_sgn_b && bus.DATA2[XLEN-1];
    assign w_mag_a = w_nega ? -bus.DATA1 : bus.DATA1;
    assign w_mag_b = w_negb ? -bus.DATA2 : bus.DATA2;

    // One multiply step: conditional add with carry out, then shift {carry, hi, lo} right.
    assign w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : {(XLEN+1){1'b0}});
    // One divide step: shift {r, q} left and trial-subtract the divisor.
    assign w_shift = {r_hi, r_lo[XLEN-1]};
    assign w_diff  = w_shift - {1'b0, r_opnd};

    always_comb begin
        w_state_nx  = r_state;
        w_cnt_nx    = r_cnt;
        w_op_nx     = r_op;
        w_nega_nx   = r_nega;
        w_negb_nx   = r_negb;
        w_opnd_nx   = r_opnd;
        w_hi_nx     = r_hi;
        w_lo_nx     = r_lo;
        w_result_nx = r_result;
        w_valid_nx  = r_valid;
        w_prod      = '0;
        w_q         = '0;
        w_r         = '0;

        if (bus.FLUSH) begin
            w_state_nx = StIdle;
            w_valid_nx = 1'b0;
            w_cnt_nx   = '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (bus.START) begin
                        w_op_nx   = w_func;
                        w_nega_nx = w_nega;
                        w_negb_nx = w_negb;
                        w_cnt_nx  = '0;
                        w_hi_nx   = '0;
                        if (!w_is_m) begin
                            w_lo_nx    = '0;
                            w_state_nx = StDone;
                        end else if (!w_func[2]) begin
                            w_opnd_nx  = w_mag_a;
                            w_lo_nx    = w_mag_b;
                            w_state_nx = StMul;
                        end else if (bus.DATA2 == '0) begin
                            w_lo_nx    = w_func[1] ? bus.DATA1 : {XLEN{1'b1}};
                            w_state_nx = StDone;
                        end else if (!w_func[0] && bus.DATA1 == MinInt &&
                                     bus.DATA2 == {XLEN{1'b1}}) begin
                            w_lo_nx    = w_func[1] ? '0 : MinInt;
                            w_state_nx = StDone;
                        end else begin
                            w_opnd_nx  = w_mag_b;
                            w_lo_nx    = w_mag_a;
                            w_state_nx = StDiv;
                        end
                    end
                end
                StMul: begin
                    w_hi_nx  = w_sum[XLEN:1];
                    w_lo_nx  = {w_sum[0], r_lo[XLEN-1:1]};
                    w_cnt_nx = r_cnt + CNT_W'(1);
                    if (r_cnt == CntMax) begin
                        w_prod = {w_sum, r_lo[XLEN-1:1]};
                        if (r_nega ^ r_negb) begin
                            w_prod = -w_prod;
                        end
                        w_lo_nx    = (r_op == 3'd0) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
                        w_cnt_nx   = '0;
                        w_state_nx = StDone;
                    end
                end
                StDiv: begin
                    if (!w_diff[XLEN]) begin
                        w_hi_nx = w_diff[XLEN-1:0];
                        w_lo_nx = {r_lo[XLEN-2:0], 1'b1};
                    end else begin
                        w_hi_nx = w_shift[XLEN-1:0];
                        w_lo_nx = {r_lo[XLEN-2:0], 1'b0};
                    end
                    w_cnt_nx = r_cnt + CNT_W'(1);
                    if (r_cnt == CntMax) begin
                        w_q        = (r_nega ^ r_negb) ? -w_lo_nx : w_lo_nx;
                        w_r        = r_nega ? -w_hi_nx : w_hi_nx;
                        w_lo_nx    = r_op[1] ? w_r : w_q;
                        w_cnt_nx   = '0;
                        w_state_nx = StDone;
                    end
                end
                StDone: begin
                    if (!r_valid) begin
                        w_result_nx = r_lo;
                        w_valid_nx  = 1'b1;
                    end else if (bus.ACK) begin
                        w_valid_nx = 1'b0;
                        w_state_nx = StIdle;
                    end
                end
                default: w_state_nx = StIdle;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_state  <= StIdle;
            r_cnt    <= '0;
            r_op     <= '0;
            r_nega   <= 1'b0;
            r_negb   <= 1'b0;
            r_opnd   <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_result <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_cnt    <= w_cnt_nx;
            r_op     <= w_op_nx;
            r_nega   <= w_nega_nx;
            r_negb   <= w_negb_nx;
            r_opnd   <= w_opnd_nx;
            r_hi     <= w_hi_nx;
            r_lo     <= w_lo_nx;
            r_result <= w_result_nx;
            r_valid  <= w_valid_nx;
        end
    end

    assign bus.READY  = (r_state == StIdle);
    assign bus.BUSY   = (r_state != StIdle);
    assign bus.RESULT = r_result;
    assign bus.VALID  = r_valid;
endmodule

// File: tb/tb_muldiv_seq.sv
// Directed and randomized checks of muldiv_seq against an arithmetic reference model.
module tb_muldiv_seq;
    logic CLK = 1'b0;
    logic RESETN = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    muldiv_seq_if #(.XLEN(32)) u_if ();

    muldiv_seq #(.XLEN(32), .CNT_W(5)) u_dut (
        .CLK    (CLK),
        .RESETN (RESETN),
        .bus    (u_if.slave)
    );

    always #5 CLK = ~CLK;

    localparam logic [4:0] SelMul    = 5'b00001;
    localparam logic [4:0] SelMulh   = 5'b00101;
    localparam logic [4:0] SelMulhsu = 5'b01001;
    localparam logic [4:0] SelMulhu  = 5'b01101;
    localparam logic [4:0] SelDiv    = 5'b10001;
    localparam logic [4:0] SelDivu   = 5'b10101;
    localparam logic [4:0] SelRem    = 5'b11001;
    localparam logic [4:0] SelRemu   = 5'b11101;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // RV32M results from plain 64-bit arithmetic.
    function automatic logic [31:0] ref_res(input logic [4:0] sel, input logic [31:0] a,
                                            input logic [31:0] b);
        longint     sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        if (sel[1:0] != 2'b01) return 32'h0;
        case (sel[4:2])
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'($signed(a) / $signed(b));
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return 32'($signed(a) % $signed(b));
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [4:0] sel, input logic [31:0] a,
                                   input logic [31:0] b);
        if (sel[1:0] != 2'b01) return 1;
        if (!sel[4]) return 33;
        if (b == 0) return 1;
        if (!sel[2] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Issue one op, measure latency, optionally stall ACK, then retire it.
    task automatic run_op(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int exp_lat, input int hold,
                          input string tag);
        int lat;
        u_if.SELECT = sel;
        u_if.DATA1  = a;
        u_if.DATA2  = b;
        u_if.START  = 1'b1;
        u_if.ACK    = 1'b0;
        @(posedge CLK);
        #1;
        u_if.START  = 1'b0;
        u_if.SELECT = 5'($urandom);
        u_if.DATA1  = $urandom;
        u_if.DATA2  = $urandom;
        lat = 0;
        while (u_if.VALID !== 1'b1 && lat < 100) begin
            @(posedge CLK);
            #1;
            lat++;
        end
        chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, " result"}, u_if.RESULT, exp);
        u_if.START = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(posedge CLK);
            #1;
            chk({tag, " valid held"}, 32'(u_if.VALID), 32'd1);
            chk({tag, " result held"}, u_if.RESULT, exp);
        end
        u_if.START = 1'b0;
        u_if.ACK   = 1'b1;
        @(posedge CLK);
        #1;
        u_if.ACK = 1'b0;
        chk({tag, " valid drop"}, 32'(u_if.VALID), 32'd0);
        chk({tag, " ready back"}, 32'(u_if.READY), 32'd1);
    endtask

    initial begin
        logic [4:0]  sel;
        logic [31:0] a, b;
        logic        seen_valid;

        u_if.START  = 1'b0;
        u_if.SELECT = '0;
        u_if.DATA1  = '0;
        u_if.DATA2  = '0;
        u_if.FLUSH  = 1'b0;
        u_if.ACK    = 1'b0;
        #12;
        chk("reset READY", 32'(u_if.READY), 32'd1);
        chk("reset BUSY", 32'(u_if.BUSY), 32'd0);
        chk("reset VALID", 32'(u_if.VALID), 32'd0);
        chk("reset RESULT", u_if.RESULT, 32'd0);
        RESETN = 1'b1;
        @(posedge CLK);
        #1;

        run_op(SelMul, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 0, "mul 7*-3");
        chk("idle BUSY", 32'(u_if.BUSY), 32'd0);
        run_op(SelMulh, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 33, 0, "mulh");
        run_op(SelMulhsu, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33, 0, "mulhsu");
        run_op(SelMulhu, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 33, 0, "mulhu");
        run_op(SelDiv, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 0, "div -7/2");
        run_op(SelRem, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 0, "rem -7/2");
        run_op(SelDivu, 32'hFFFF_FFFE, 32'd3, 32'h5555_5554, 33, 0, "divu");
        run_op(SelRemu, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 33, 0, "remu");
        run_op(SelDiv, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0, "div by 0");
        run_op(SelRemu, 32'd5, 32'd0, 32'd5, 1, 0, "remu by 0");
        run_op(SelDiv, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0, "div ovf");
        run_op(SelRem, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1, 0, "rem ovf");
        run_op(5'b00000, 32'd9, 32'd9, 32'h0, 1, 0, "bad select");
        run_op(SelDivu, 32'd100, 32'd7, 32'd14, 33, 5, "ack stall");

        // Flush a divide during its tenth iteration.
        u_if.SELECT = SelDiv;
        u_if.DATA1  = 32'd1000;
        u_if.DATA2  = 32'd7;
        u_if.START  = 1'b1;
        @(posedge CLK);
        #1;
        u_if.START = 1'b0;
        repeat (9) @(posedge CLK);
        #1;
        u_if.FLUSH = 1'b1;
        @(posedge CLK);
        #1;
        u_if.FLUSH = 1'b0;
        chk("flush BUSY", 32'(u_if.BUSY), 32'd0);
        chk("flush READY", 32'(u_if.READY), 32'd1);
        seen_valid = 1'b0;
        repeat (40) begin
            @(posedge CLK);
            #1;
            seen_valid |= u_if.VALID;
        end
        chk("flush no VALID", 32'(seen_valid), 32'd0);

        // START with FLUSH must not be accepted.
        u_if.SELECT = SelDiv;
        u_if.DATA1  = 32'd5;
        u_if.DATA2  = 32'd0;
        u_if.START  = 1'b1;
        u_if.FLUSH  = 1'b1;
        @(posedge CLK);
        #1;
        u_if.START = 1'b0;
        u_if.FLUSH = 1'b0;
        chk("start+flush BUSY", 32'(u_if.BUSY), 32'd0);
        @(posedge CLK);
        #1;
        chk("start+flush VALID", 32'(u_if.VALID), 32'd0);

        // Asynchronous reset in the middle of a multiply.
        u_if.SELECT = SelMul;
        u_if.DATA1  = 32'd123;
        u_if.DATA2  = 32'd456;
        u_if.START  = 1'b1;
        @(posedge CLK);
        #1;
        u_if.START = 1'b0;
        repeat (5) @(posedge CLK);
        #2;
        RESETN = 1'b0;
        #1;
        chk("mid reset READY", 32'(u_if.READY), 32'd1);
        chk("mid reset BUSY", 32'(u_if.BUSY), 32'd0);
        chk("mid reset VALID", 32'(u_if.VALID), 32'd0);
        chk("mid reset RESULT", u_if.RESULT, 32'd0);
        #1;
        RESETN = 1'b1;
        @(posedge CLK);
        #1;
        run_op(SelMul, 32'd3, 32'd4, 32'd12, 33, 0, "mul after reset");

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 9) == 0) sel = 5'($urandom);
            else sel = {3'($urandom_range(0, 7)), 2'b01};
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 15));
                3: b = -32'($urandom_range(1, 15));
                default: ;
            endcase
            run_op(sel, a, b, ref_res(sel, a, b), ref_lat(sel, a, b), i % 3, "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Multi-cycle sequencer for the RV32M operations: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- Replaces the single-cycle combinational multiply/divide paths in the execute stage with one shared 32-iteration shift-add/shift-subtract engine.
- Sits beside the ALU. The pipeline hands over an operation with a valid/ready handshake and stalls on BUSY until the result is taken.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- CNT_W, 5, iteration counter width (log2 XLEN).

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RESETN  input  1  asynchronous, active-low reset.
- START  input  1  request valid.
- READY  output  1  unit can accept; high only in IDLE.
- SELECT  input  5  {func3, func7[5], func7[0]}. MUL=00001, MULH=00101, MULHSU=01001, MULHU=01101, DIV=10001, DIVU=10101, REM=11001, REMU=11101.
- DATA1  input  32  rs1 operand (dividend / multiplicand).
- DATA2  input  32  rs2 operand (divisor / multiplier).
- FLUSH  input  1  synchronous abort from pipeline.
- RESULT  output  32  result, registered; stable while VALID.
- VALID  output  1  RESULT valid.
- ACK  input  1  consumer accepts RESULT.
- BUSY  output  1  high in any state except IDLE.

Behaviour:
- Reset (RESETN=0, asynchronous):
  - State goes to IDLE and the counter clears.
  - Outputs: RESULT=0, VALID=0, READY=1, BUSY=0.
- States: IDLE, MUL, DIV, DONE.
- Accept: START&&READY at rising edge N latches SELECT, DATA1 and DATA2.
  - Computes sign flags: negA = signed op && DATA1[31]; negB = signed-for-rs2 op (MULH, DIV, REM) && DATA2[31].
  - Stores operand magnitudes (two's-complement negate if the flag is set).
- IDLE transitions at edge N:
  - MUL*: go to MUL.
  - DIV/DIVU/REM/REMU with DATA2==0: go to DONE. Result: DIV/DIVU=0xFFFFFFFF; REM/REMU=DATA1.
  - DIV/REM with DATA1=0x80000000 and DATA2=0xFFFFFFFF: go to DONE. Result: DIV=0x80000000, REM=0.
  - SELECT not in the M encoding list: go to DONE with RESULT=0.
  - Other divides: go to DIV.
  - Every fast path gives VALID=1 after edge N+1, i.e. visible one cycle after acceptance.
- MUL state:
  - 64-bit product register {hi, lo}; lo is initialised to |multiplier|.
  - Each edge: if lo[0], add |multiplicand| into hi with a 33-bit carry, then shift the 65-bit {carry, hi, lo} right by 1.
  - 32 iterations on edges N+1..N+32; the counter increments from 0 to 31.
  - At the 32nd iteration, negate the 64-bit product if negA^negB.
  - Select RESULT: lo for MUL, hi for the others. Go to DONE.
- DIV state: restoring division.
  - Remainder register r is 33 bits; quotient register q starts at |dividend|.
  - Each edge: shift {r, q} left by 1, then trial subtract |divisor| from r.
  - If non-negative, keep the difference and set q[0]=1; otherwise restore r.
  - 32 iterations on edges N+1..N+32.
  - At the final iteration: quotient = negA^negB ? -q : q; remainder = negA ? -r : r. DIVU/REMU are unsigned, so no negation.
- Latency:
  - Normal path: VALID high after edge N+33.
  - MUL/DIV iteration count is fixed (no early termination).
- DONE:
  - VALID=1; RESULT held stable.
  - ACK=1 at an edge: go to IDLE and VALID=0 the same edge.
  - ACK=0: hold indefinitely.
  - A START while in DONE is ignored because READY=0.
- Back-to-back:
  - A new START can be accepted only in the cycle after ACK.
  - Throughput is 1 op per 35 cycles minimum for normal ops and 3 cycles for fast paths.
- FLUSH:
  - FLUSH=1 at any edge forces IDLE, VALID=0, counter=0. RESULT keeps its last value.
  - FLUSH has priority over START (the request is not accepted) and over ACK.
- Reset mid-operation: immediately returns all state to reset values; no result is produced.
- Input changes: DATA1, DATA2 and SELECT changing after acceptance have no effect on the result.
- Arithmetic: all results are exact 32-bit RV32M semantics. Signed division rounds toward zero; the remainder takes the sign of the dividend.

Test Plan:
- Basic MUL: MUL 7×(−3) (DATA2=0xFFFFFFFD) -> VALID exactly 33 cycles after accept, RESULT=0xFFFFFFEB; with ACK held 1, VALID drops next edge and READY returns high.
- High multiplies: MULH/MULHSU/MULHU with DATA1=0x80000000, DATA2=0xFFFFFFFF -> MULH=0x00000000; MULHSU=0x80000000; MULHU=0x7FFFFFFF.
- Signed DIV/REM: DIV −7/2 -> 0xFFFFFFFD; REM −7/2 -> 0xFFFFFFFF; DIVU 0xFFFFFFFE/3 -> 0x55555554; REMU -> 0x00000002. All with 33-cycle latency.
- Corner fast paths: DIV 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; DIV 0x80000000/−1 -> 0x80000000; REM -> 0; SELECT=00000 -> RESULT 0. VALID one cycle after accept in every case.
- Control: FLUSH asserted at iteration 10 of a DIV -> IDLE next edge, VALID never rises. START+FLUSH in the same cycle -> not accepted. ACK held 0 for 5 cycles in DONE -> RESULT stable, VALID held.
- Reset mid-operation: RESETN pulsed low asynchronously mid-MUL -> outputs at reset values immediately. Afterwards, a new MUL 3×4 -> 12 after 33 cycles.
